// File: rtl/control_queue.sv
// control_queue: arbitrated command FIFO with sticky overflow and flush.
// Optional: define CONTROL_QUEUE_COALESCE_EN to drop candidates equal to the tail.
module control_queue #(
  parameter int DEPTH = 16,
  parameter int NSRC  = 2,
  parameter int CMD_W = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NSRC-1:0]         src_valid,
  input  logic [NSRC*CMD_W-1:0]   src_cmd,
  input  logic                    pop,
  input  logic                    flush,
  output logic [CMD_W-1:0]        cmd_out,
  output logic                    cmd_valid,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf;

  logic             cand_hit;
  logic [CMD_W-1:0] cand;
  logic [CMD_W-1:0] tail;
  logic             empty;
  logic             is_full;
  logic             do_pop;
  logic             dup;
  logic             has_room;
  logic             do_push;
  logic             drop;

  // Lowest-index source carrying a real command wins.
  always_comb begin
    cand_hit = 1'b0;
    cand     = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (!cand_hit && src_valid[i] &&
          src_cmd[i*CMD_W +: CMD_W] != '0) begin
        cand_hit = 1'b1;
        cand     = src_cmd[i*CMD_W +: CMD_W];
      end
    end
  end

  assign empty    = (cnt == '0);
  assign is_full  = (cnt == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign tail     = mem[wr_ptr - AW'(1)];
  assign has_room = !is_full || do_pop;

`ifdef CONTROL_QUEUE_COALESCE_EN
  // Tail is the pre-pop value, so a lone popped entry still absorbs a repeat.
  assign dup = !empty && (cand == tail);
`else
  assign dup = 1'b0;
`endif

  assign do_push = cand_hit && !dup && has_room;
  assign drop    = cand_hit && !dup && !has_room;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        (do_push && !do_pop): cnt <= cnt + CW'(1);
        (!do_push && do_pop): cnt <= cnt - CW'(1);
        default:              cnt <= cnt;
      endcase
      if (drop)
        ovf <= 1'b1;
    end
  end

  // Storage needs no reset; reads are masked by the count.
  always_ff @(posedge clk) begin
    if (reset_n && !flush && do_push)
      mem[wr_ptr] <= cand;
  end

  assign cmd_out   = empty ? '0 : mem[rd_ptr];
  assign cmd_valid = !empty;
  assign count     = cnt;
  assign full      = is_full;
  assign overflow  = ovf;

endmodule

// File: tb/tb_control_queue.sv
// tb_control_queue: directed vectors plus a queue-based reference model.
// Honours CONTROL_QUEUE_COALESCE_EN the same way the design does.
module tb_control_queue;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] src_valid = '0;
  logic [7:0] src_cmd = '0;
  logic       pop = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] cmd_out;
  logic       cmd_valid;
  logic [4:0] count;
  logic       full;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  int q[$];
  bit m_ovf = 1'b0;

  control_queue #(.DEPTH(16), .NSRC(2), .CMD_W(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .src_valid(src_valid),
    .src_cmd(src_cmd),
    .pop(pop),
    .flush(flush),
    .cmd_out(cmd_out),
    .cmd_valid(cmd_valid),
    .count(count),
    .full(full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue semantics straight from the rules.
  always @(posedge clk) begin
    int  cand;
    bit  take;
    bit  pdo;
    cand = 0;
    if (!reset_n) begin
      q.delete();
      m_ovf = 1'b0;
    end else if (flush) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (src_valid[0] && src_cmd[3:0] != 0)
        cand = int'(src_cmd[3:0]);
      else if (src_valid[1] && src_cmd[7:4] != 0)
        cand = int'(src_cmd[7:4]);
      pdo  = pop && q.size() > 0;
      take = cand != 0;
`ifdef CONTROL_QUEUE_COALESCE_EN
      if (take && q.size() > 0 && q[q.size()-1] == cand)
        take = 1'b0;
`endif
      if (pdo)
        void'(q.pop_front());
      if (take) begin
        if (q.size() < 16)
          q.push_back(cand);
        else
          m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("mdl_count", int'(count), q.size());
      check("mdl_valid", int'(cmd_valid), int'(q.size() > 0));
      check("mdl_cmd", int'(cmd_out), q.size() > 0 ? q[0] : 0);
      check("mdl_full", int'(full), int'(q.size() == 16));
      check("mdl_ovf", int'(overflow), int'(m_ovf));
    end
  end

  task automatic cyc(input logic v0, input logic [3:0] c0,
                     input logic v1, input logic [3:0] c1,
                     input logic p, input logic f);
    src_valid = {v1, v0};
    src_cmd   = {c1, c0};
    pop       = p;
    flush     = f;
    @(posedge clk);
    @(negedge clk);
    src_valid = '0;
    src_cmd   = '0;
    pop       = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic push(input logic [3:0] c);
    cyc(1'b1, c, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_pop();
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic do_flush();
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    cyc(1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b1);
    chk_on = 1'b1;
    check("rst_count", int'(count), 0);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_cmd", int'(cmd_out), 0);
    check("rst_full", int'(full), 0);
    check("rst_ovf", int'(overflow), 0);
    reset_n = 1'b1;

    push(4'd3);
    push(4'd5);
    push(4'd7);
    check("fifo_count", int'(count), 3);
    check("fifo_head", int'(cmd_out), 3);
    do_pop();
    check("pop1", int'(cmd_out), 5);
    do_pop();
    check("pop2", int'(cmd_out), 7);
    do_pop();
    check("pop3_cmd", int'(cmd_out), 0);
    check("pop3_valid", int'(cmd_valid), 0);

    cyc(1'b1, 4'd4, 1'b1, 4'd6, 1'b0, 1'b0);
    check("arb_count", int'(count), 1);
    check("arb_head", int'(cmd_out), 4);
    cyc(1'b1, 4'd0, 1'b1, 4'd6, 1'b0, 1'b0);
    check("none_skip", int'(count), 2);
    do_flush();

    for (int i = 0; i < 16; i++)
      push(4'(i % 15 + 1));
    check("fill_count", int'(count), 16);
    check("fill_full", int'(full), 1);
    push(4'd9);
    check("ovf_count", int'(count), 16);
    check("ovf_set", int'(overflow), 1);
    cyc(1'b1, 4'd9, 1'b0, 4'd0, 1'b1, 1'b0);
    check("fullpp_count", int'(count), 16);
    check("fullpp_ovf", int'(overflow), 1);
    for (int i = 0; i < 15; i++)
      do_pop();
    check("tail_is_9", int'(cmd_out), 9);
    do_pop();

    for (int i = 1; i <= 5; i++)
      push(4'(i));
    cyc(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b1);
    check("flush_count", int'(count), 0);
    check("flush_cmd", int'(cmd_out), 0);
    check("flush_ovf", int'(overflow), 0);

    push(4'd3);
    push(4'd3);
    push(4'd3);
    push(4'd5);
`ifdef CONTROL_QUEUE_COALESCE_EN
    check("coal_count", int'(count), 2);
    do_pop();
    check("coal_second", int'(cmd_out), 5);
`else
    check("coal_count", int'(count), 4);
    do_pop();
    check("coal_second", int'(cmd_out), 3);
`endif
    do_flush();

    push(4'd8);
    cyc(1'b1, 4'd8, 1'b0, 4'd0, 1'b1, 1'b0);
`ifdef CONTROL_QUEUE_COALESCE_EN
    check("prepop_tail", int'(count), 0);
`else
    check("prepop_tail", int'(count), 1);
`endif
    do_flush();

    for (int i = 0; i < 4; i++) begin
      do_pop();
      check("empty_pop", int'(count), 0);
    end
    src_valid = 2'b01;
    src_cmd   = 8'h01;
    #1;
    check("no_bypass", int'(cmd_valid), 0);
    @(posedge clk);
    @(negedge clk);
    src_valid = '0;
    src_cmd   = '0;
    check("lat_count", int'(count), 1);
    check("lat_cmd", int'(cmd_out), 1);

    push(4'd2);
    reset_n = 1'b0;
    cyc(1'b1, 4'd6, 1'b0, 4'd0, 1'b1, 1'b0);
    check("midrst_count", int'(count), 0);
    check("midrst_valid", int'(cmd_valid), 0);
    reset_n = 1'b1;
    push(4'd11);
    check("post_rst_head", int'(cmd_out), 11);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
